// File: rtl/eth_udp_pkg.sv
// Shared types and limits for the UDP session controller.
package eth_udp_pkg;

    localparam int unsigned LEN_W           = 16;
    localparam int unsigned CNT_W           = 32;
    localparam int unsigned MTU_PAYLOAD_MAX = 1472;

    // One-hot session state.
    typedef enum logic [9:0] {
        ST_IDLE      = 10'b00_0000_0001,
        ST_ARP_REQ   = 10'b00_0000_0010,
        ST_ARP_SEND  = 10'b00_0000_0100,
        ST_ARP_WAIT  = 10'b00_0000_1000,
        ST_ERROR     = 10'b00_0001_0000,
        ST_READY     = 10'b00_0010_0000,
        ST_CHECK_ARP = 10'b00_0100_0000,
        ST_GEN_REQ   = 10'b00_1000_0000,
        ST_WRITE     = 10'b01_0000_0000,
        ST_SEND_WAIT = 10'b10_0000_0000
    } state_t;

    // Largest payload length the controller will accept.
    function automatic int unsigned len_limit(input int unsigned max_bytes);
        return (max_bytes < MTU_PAYLOAD_MAX) ? max_bytes : MTU_PAYLOAD_MAX;
    endfunction

endpackage

// File: rtl/eth_udp_session_ctrl_udp_tx_serializer.sv
// Turns a latched MSB-first payload word into a registered byte stream.
module udp_tx_serializer
    import eth_udp_pkg::*;
#(
    parameter int unsigned MAX_BYTES = 120
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_start,
    input  logic [MAX_BYTES*8-1:0] i_word,
    input  logic [LEN_W-1:0]       i_len,
    output logic                   o_valid,
    output logic [7:0]             o_data,
    output logic                   o_done
);

    localparam int unsigned W = MAX_BYTES * 8;

    logic             r_busy;
    logic [LEN_W-1:0] r_idx;
    logic             r_valid;
    logic [7:0]       r_data;
    logic             r_done;
    logic [W-1:0]     w_shift;

    // Byte r_idx moved to the top of the word.
    assign w_shift = i_word << {r_idx, 3'b000};

    // Walk the byte index; done coincides with the last byte.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_busy  <= 1'b0;
            r_idx   <= '0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_busy  <= 1'b1;
                r_idx   <= '0;
                r_valid <= 1'b0;
            end else if (r_busy) begin
                r_valid <= 1'b1;
                r_data  <= w_shift[W-1 -: 8];
                r_idx   <= r_idx + LEN_W'(1);
                if (r_idx == i_len - LEN_W'(1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_done  = r_done;

endmodule

// File: rtl/eth_udp_session_ctrl.sv
// Application-side session controller: ARP resolution, TX serialisation, RX capture.
module eth_udp_session_ctrl
    import eth_udp_pkg::*;
#(
    parameter int unsigned TX_MAX_BYTES    = 120,
    parameter int unsigned RX_MAX_BYTES    = 160,
    parameter int unsigned STARTUP_CNT     = 125_000_000,
    parameter int unsigned ARP_TIMEOUT_CNT = 125_000_000,
    parameter int unsigned ARP_RETRY_MAX   = 4,
    parameter int unsigned ERR_BACKOFF_CNT = 250_000_000,
    parameter int unsigned REFRESH_EN      = 1,
    parameter int unsigned REFRESH_CNT     = 125_000_000
) (
    input  logic                      rgmii_clk,
    input  logic                      rst,
    input  logic                      tx_valid,
    output logic                      tx_ready,
    input  logic [TX_MAX_BYTES*8-1:0] tx_data,
    input  logic [15:0]               tx_len,
    output logic                      tx_done,
    output logic                      tx_err,
    output logic                      link_up,
    output logic                      arp_fail,
    output logic                      arp_req,
    input  logic                      arp_found,
    input  logic                      mac_not_exist,
    input  logic                      mac_send_end,
    output logic                      app_data_request,
    input  logic                      udp_send_ack,
    output logic                      app_data_in_valid,
    output logic [7:0]                app_data_in,
    output logic [15:0]               app_data_length,
    input  logic                      udp_rec_data_valid,
    input  logic [7:0]                udp_rec_rdata,
    output logic [RX_MAX_BYTES*8-1:0] rx_data,
    output logic [15:0]               rx_len,
    output logic                      rx_done,
    output logic                      rx_overflow
);

    localparam int unsigned TX_W      = TX_MAX_BYTES * 8;
    localparam int unsigned RX_W      = RX_MAX_BYTES * 8;
    localparam int unsigned LEN_LIMIT = len_limit(TX_MAX_BYTES);

    state_t           r_state, w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_retry;
    logic             r_pending;
    logic [TX_W-1:0]  r_tx_word;
    logic [LEN_W-1:0] r_tx_len;
    logic             r_tx_ready, r_tx_done, r_tx_err, r_link_up;
    logic             r_arp_fail, r_arp_req, r_app_req;
    logic             w_req, w_len_ok, w_accept, w_reject;
    logic             w_cnt_run, w_ser_start, w_ser_done;

    assign w_req     = (r_state == ST_READY) && tx_valid;
    assign w_len_ok  = (tx_len != '0) && (tx_len <= LEN_W'(LEN_LIMIT));
    assign w_accept  = w_req && w_len_ok;
    assign w_reject  = w_req && !w_len_ok;
    assign w_cnt_run = (r_state == ST_IDLE) || (r_state == ST_ARP_WAIT) ||
                       (r_state == ST_ERROR) || (r_state == ST_READY);

    // State register.
    always_ff @(posedge rgmii_clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // Next-state decode.
    always_comb begin
        w_next      = r_state;
        w_ser_start = 1'b0;
        case (r_state)
            ST_IDLE:      if (r_cnt == CNT_W'(STARTUP_CNT - 1)) w_next = ST_ARP_REQ;
            ST_ARP_REQ:   w_next = ST_ARP_SEND;
            ST_ARP_SEND:  if (mac_send_end) w_next = ST_ARP_WAIT;
            ST_ARP_WAIT: begin
                if (arp_found)
                    w_next = r_pending ? ST_CHECK_ARP : ST_READY;
                else if (r_cnt == CNT_W'(ARP_TIMEOUT_CNT - 1))
                    w_next = (r_retry < CNT_W'(ARP_RETRY_MAX)) ? ST_ARP_REQ : ST_ERROR;
            end
            ST_ERROR:     if (r_cnt == CNT_W'(ERR_BACKOFF_CNT - 1)) w_next = ST_ARP_REQ;
            ST_READY: begin
                if (w_accept)
                    w_next = ST_CHECK_ARP;
                else if (!tx_valid && (REFRESH_EN != 0) && (r_cnt >= CNT_W'(REFRESH_CNT - 1)))
                    w_next = ST_CHECK_ARP;
            end
            ST_CHECK_ARP: begin
                if (mac_not_exist)  w_next = ST_ARP_REQ;
                else if (r_pending) w_next = ST_GEN_REQ;
                else                w_next = ST_READY;
            end
            ST_GEN_REQ: begin
                if (udp_send_ack) begin
                    w_next      = ST_WRITE;
                    w_ser_start = 1'b1;
                end
            end
            ST_WRITE:     if (w_ser_done) w_next = ST_SEND_WAIT;
            ST_SEND_WAIT: if (mac_send_end) w_next = ST_READY;
            default:      w_next = ST_IDLE;
        endcase
    end

    // Shared timer: restarts on every state change.
    always_ff @(posedge rgmii_clk or posedge rst) begin
        if (rst)                   r_cnt <= '0;
        else if (w_next != r_state) r_cnt <= '0;
        else if (w_cnt_run)        r_cnt <= r_cnt + CNT_W'(1);
    end

    // ARP attempt counter.
    always_ff @(posedge rgmii_clk or posedge rst) begin
        if (rst)
            r_retry <= '0;
        else if (r_state == ST_ARP_REQ)
            r_retry <= r_retry + CNT_W'(1);
        else if ((r_state == ST_ARP_WAIT && arp_found) ||
                 (r_state == ST_ERROR && w_next == ST_ARP_REQ))
            r_retry <= '0;
    end

    // Pending payload latch; survives an ARP re-resolution.
    always_ff @(posedge rgmii_clk or posedge rst) begin
        if (rst) begin
            r_pending <= 1'b0;
            r_tx_word <= '0;
            r_tx_len  <= '0;
        end else if (w_accept) begin
            r_pending <= 1'b1;
            r_tx_word <= tx_data;
            r_tx_len  <= tx_len;
        end else if (r_state == ST_SEND_WAIT && mac_send_end) begin
            r_pending <= 1'b0;
        end
    end

    // Registered control outputs, decoded from the upcoming state so they align with it.
    always_ff @(posedge rgmii_clk or posedge rst) begin
        if (rst) begin
            r_tx_ready <= 1'b0;
            r_tx_done  <= 1'b0;
            r_tx_err   <= 1'b0;
            r_link_up  <= 1'b0;
            r_arp_fail <= 1'b0;
            r_arp_req  <= 1'b0;
            r_app_req  <= 1'b0;
        end else begin
            r_tx_ready <= (w_next == ST_READY);
            r_arp_fail <= (w_next == ST_ERROR);
            r_arp_req  <= (w_next == ST_ARP_REQ);
            r_app_req  <= (w_next == ST_GEN_REQ);
            r_tx_err   <= w_reject;
            r_tx_done  <= (r_state == ST_SEND_WAIT) && mac_send_end;
            if (r_state == ST_ARP_WAIT && arp_found)
                r_link_up <= 1'b1;
            else if (w_next == ST_ERROR || (r_state == ST_CHECK_ARP && mac_not_exist))
                r_link_up <= 1'b0;
        end
    end

    udp_tx_serializer #(
        .MAX_BYTES (TX_MAX_BYTES)
    ) u_ser (
        .i_clk   (rgmii_clk),
        .i_rst   (rst),
        .i_start (w_ser_start),
        .i_word  (r_tx_word),
        .i_len   (r_tx_len),
        .o_valid (app_data_in_valid),
        .o_data  (app_data_in),
        .o_done  (w_ser_done)
    );

    // ---------------- RX capture ----------------
    logic             r_rx_vld_d, r_rx_ovf_acc, r_rx_fall_d;
    logic             r_rx_done, r_rx_ovf;
    logic [LEN_W-1:0] r_rx_idx, r_rx_len;
    logic [RX_W-1:0]  r_rx_data;
    logic             w_rx_rise, w_rx_fall, w_rx_in_range;
    logic [LEN_W-1:0] w_rx_idx;
    logic [RX_W-1:0]  w_rx_base, w_rx_byte;

    assign w_rx_rise     = udp_rec_data_valid && !r_rx_vld_d;
    assign w_rx_fall     = !udp_rec_data_valid && r_rx_vld_d;
    assign w_rx_idx      = w_rx_rise ? '0 : r_rx_idx;
    assign w_rx_in_range = w_rx_idx < LEN_W'(RX_MAX_BYTES);
    assign w_rx_base     = w_rx_rise ? '0 : r_rx_data;
    assign w_rx_byte     = {udp_rec_rdata, {(RX_W-8){1'b0}}} >> {w_rx_idx, 3'b000};

    // Byte capture, saturating index and end-of-packet reporting.
    always_ff @(posedge rgmii_clk or posedge rst) begin
        if (rst) begin
            r_rx_vld_d   <= 1'b0;
            r_rx_ovf_acc <= 1'b0;
            r_rx_fall_d  <= 1'b0;
            r_rx_done    <= 1'b0;
            r_rx_ovf     <= 1'b0;
            r_rx_idx     <= '0;
            r_rx_len     <= '0;
            r_rx_data    <= '0;
        end else begin
            r_rx_vld_d  <= udp_rec_data_valid;
            r_rx_fall_d <= w_rx_fall;
            r_rx_done   <= r_rx_fall_d;
            if (udp_rec_data_valid) begin
                r_rx_data    <= w_rx_in_range ? (w_rx_base | w_rx_byte) : w_rx_base;
                r_rx_ovf_acc <= (w_rx_rise ? 1'b0 : r_rx_ovf_acc) | !w_rx_in_range;
                r_rx_idx     <= (w_rx_idx == '1) ? w_rx_idx : w_rx_idx + LEN_W'(1);
            end
            if (w_rx_fall) begin
                r_rx_len <= r_rx_idx;
                r_rx_ovf <= r_rx_ovf_acc;
            end
        end
    end

    assign tx_ready         = r_tx_ready;
    assign tx_done          = r_tx_done;
    assign tx_err           = r_tx_err;
    assign link_up          = r_link_up;
    assign arp_fail         = r_arp_fail;
    assign arp_req          = r_arp_req;
    assign app_data_request = r_app_req;
    assign app_data_length  = r_tx_len;
    assign rx_data          = r_rx_data;
    assign rx_len           = r_rx_len;
    assign rx_done          = r_rx_done;
    assign rx_overflow      = r_rx_ovf;

endmodule

// File: tb/tb_eth_udp_session_ctrl.sv
// Scoreboard bench for eth_udp_session_ctrl with a small behavioural stack responder.
module tb_eth_udp_session_ctrl;

    localparam int unsigned TXB = 8;
    localparam int unsigned RXB = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            tx_valid, tx_ready, tx_done, tx_err;
    logic [TXB*8-1:0] tx_data;
    logic [15:0]     tx_len;
    logic            link_up, arp_fail, arp_req, arp_found, mac_not_exist, mac_send_end;
    logic            app_data_request, udp_send_ack, app_data_in_valid;
    logic [7:0]      app_data_in;
    logic [15:0]     app_data_length;
    logic            udp_rec_data_valid;
    logic [7:0]      udp_rec_rdata;
    logic [RXB*8-1:0] rx_data;
    logic [15:0]     rx_len;
    logic            rx_done, rx_overflow;

    always #5 clk = ~clk;

    eth_udp_session_ctrl #(
        .TX_MAX_BYTES(TXB), .RX_MAX_BYTES(RXB), .STARTUP_CNT(10), .ARP_TIMEOUT_CNT(20),
        .ARP_RETRY_MAX(2), .ERR_BACKOFF_CNT(30), .REFRESH_EN(1), .REFRESH_CNT(400)
    ) dut (
        .rgmii_clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .tx_len(tx_len), .tx_done(tx_done), .tx_err(tx_err), .link_up(link_up), .arp_fail(arp_fail),
        .arp_req(arp_req), .arp_found(arp_found), .mac_not_exist(mac_not_exist),
        .mac_send_end(mac_send_end), .app_data_request(app_data_request), .udp_send_ack(udp_send_ack),
        .app_data_in_valid(app_data_in_valid), .app_data_in(app_data_in),
        .app_data_length(app_data_length), .udp_rec_data_valid(udp_rec_data_valid),
        .udp_rec_rdata(udp_rec_rdata), .rx_data(rx_data), .rx_len(rx_len), .rx_done(rx_done),
        .rx_overflow(rx_overflow)
    );

    typedef struct {
        logic [15:0]      len;
        logic             ovf;
        logic [RXB*8-1:0] data;
    } rx_exp_t;

    logic [7:0]  exp_byte_q[$];
    logic [15:0] exp_len_q[$];
    rx_exp_t     exp_rx_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int n_arp = 0, n_done = 0, n_err = 0, n_req = 0, last_run = 0, cur_run = 0;
    logic req_d = 1'b0;
    logic arp_answer;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic fail(input string name);
        n_checks++;
        $display("FAIL %s: event not seen or unexpected", name);
    endtask

    // Monitor: event counters and scoreboard pops.
    initial begin : monitor
        rx_exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (arp_req) n_arp++;
                if (tx_done) n_done++;
                if (tx_err)  n_err++;
                if (app_data_request && !req_d) begin
                    n_req++;
                    if (exp_len_q.size() == 0) fail("app_data_length_unexpected");
                    else check("app_data_length", 64'(app_data_length), 64'(exp_len_q.pop_front()));
                end
                req_d = app_data_request;
                if (app_data_in_valid) begin
                    cur_run++;
                    if (exp_byte_q.size() == 0) fail("app_data_in_unexpected");
                    else check("app_data_in", 64'(app_data_in), 64'(exp_byte_q.pop_front()));
                end else if (cur_run != 0) begin
                    last_run = cur_run;
                    cur_run  = 0;
                end
                if (rx_done) begin
                    if (exp_rx_q.size() == 0) fail("rx_done_unexpected");
                    else begin
                        e = exp_rx_q.pop_front();
                        check("rx_len", 64'(rx_len), 64'(e.len));
                        check("rx_overflow", 64'(rx_overflow), 64'(e.ovf));
                        check("rx_data", 64'(rx_data), 64'(e.data));
                    end
                end
            end
        end
    end

    // Behavioural stack: answers ARP requests and data requests.
    initial begin : stack_model
        logic seen;
        mac_send_end = 1'b0;
        arp_found    = 1'b0;
        udp_send_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && arp_req) begin
                repeat (2) @(posedge clk);
                #1 mac_send_end = 1'b1;
                @(posedge clk); #1 mac_send_end = 1'b0;
                if (arp_answer) begin
                    repeat (2) @(posedge clk);
                    #1 arp_found = 1'b1;
                    @(posedge clk); #1 arp_found = 1'b0;
                end
            end else if (!rst && app_data_request) begin
                @(posedge clk); #1 udp_send_ack = 1'b1;
                @(posedge clk); #1 udp_send_ack = 1'b0;
                seen = 1'b0;
                for (int i = 0; i < 100; i++) begin
                    @(negedge clk);
                    if (app_data_in_valid) seen = 1'b1;
                    else if (seen) break;
                end
                @(posedge clk); #1 mac_send_end = 1'b1;
                @(posedge clk); #1 mac_send_end = 1'b0;
            end
        end
    end

    task automatic wait_ready();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx_ready) return;
        end
        fail("tx_ready_timeout");
    endtask

    task automatic drive_req(input logic [63:0] d, input logic [15:0] len);
        wait_ready();
        @(posedge clk); #1;
        tx_valid = 1'b1; tx_data = d; tx_len = len;
        @(posedge clk); #1;
        tx_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int base, input int run_len);
        bit got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (n_done > base) begin got = 1'b1; break; end
        end
        if (!got) fail(name);
        repeat (4) @(negedge clk);
        check({name, "_done_count"}, 64'(n_done - base), 64'd1);
        check({name, "_run_len"}, 64'(last_run), 64'(run_len));
        check({name, "_bytes_left"}, 64'(exp_byte_q.size()), 64'd0);
    endtask

    task automatic reject(input string name, input logic [15:0] len);
        int eb = n_err, rb = n_req;
        drive_req(64'hDEAD_BEEF_0102_0304, len);
        @(negedge clk);
        check({name, "_tx_err"}, 64'(tx_err), 64'd1);
        check({name, "_ready"}, 64'(tx_ready), 64'd1);
        @(negedge clk);
        check({name, "_tx_err_pulse"}, 64'(tx_err), 64'd0);
        repeat (8) @(negedge clk);
        check({name, "_err_count"}, 64'(n_err - eb), 64'd1);
        check({name, "_no_request"}, 64'(n_req - rb), 64'd0);
    endtask

    task automatic rx_burst(input logic [7:0] first, input logic [7:0] step, input int n);
        logic [7:0] b = first;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            udp_rec_data_valid = 1'b1; udp_rec_rdata = b;
            b = b + step;
        end
        @(posedge clk); #1 udp_rec_data_valid = 1'b0;
        repeat (5) @(posedge clk);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        int cyc, base, fcnt;
        bit got;
        rst = 1'b1; tx_valid = 1'b0; tx_data = '0; tx_len = '0; mac_not_exist = 1'b0;
        udp_rec_data_valid = 1'b0; udp_rec_rdata = '0; arp_answer = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx_ready", 64'(tx_ready), 64'd0);
        check("rst_link_up", 64'(link_up), 64'd0);
        check("rst_arp_req", 64'(arp_req), 64'd0);
        check("rst_arp_fail", 64'(arp_fail), 64'd0);
        check("rst_app_valid", 64'(app_data_in_valid), 64'd0);
        check("rst_rx_len", 64'(rx_len), 64'd0);

        // Startup ARP: request at cycle 10, resolution at cycle 16.
        @(posedge clk); #1 rst = 1'b0;
        cyc = 0; got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (arp_req) begin got = 1'b1; break; end
            cyc++;
        end
        check("startup_arp_req_cycle", 64'(cyc), 64'd10);
        for (int i = 0; i < 40 && !link_up; i++) begin
            @(negedge clk);
            cyc++;
        end
        check("link_up_cycle", 64'(cyc), 64'd16);
        check("link_up", 64'(link_up), 64'd1);
        check("tx_ready_after_link", 64'(tx_ready), 64'd1);

        // Unanswered ARP: two requests, 30-cycle backoff, then a new request.
        @(posedge clk); #1 rst = 1'b1; arp_answer = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        base = n_arp; got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (arp_fail) begin got = 1'b1; break; end
        end
        if (!got) fail("arp_fail_timeout");
        check("retry_arp_count", 64'(n_arp - base), 64'd2);
        check("error_link_down", 64'(link_up), 64'd0);
        arp_answer = 1'b1;
        fcnt = 1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!arp_fail) break;
            fcnt++;
        end
        check("arp_fail_cycles", 64'(fcnt), 64'd30);
        check("arp_req_after_backoff", 64'(arp_req), 64'd1);
        for (int i = 0; i < 40 && !link_up; i++) @(negedge clk);
        check("relink_up", 64'(link_up), 64'd1);

        // 5-byte payload, lower bytes must not be sent.
        base = n_done;
        exp_len_q.push_back(16'd5);
        exp_byte_q.push_back(8'h01); exp_byte_q.push_back(8'h02); exp_byte_q.push_back(8'h03);
        exp_byte_q.push_back(8'h04); exp_byte_q.push_back(8'h05);
        drive_req(64'h0102_0304_05EE_EEEE, 16'd5);
        wait_done("tx5", base, 5);

        // Length boundaries that must be rejected.
        reject("len0", 16'd0);
        reject("len_over", 16'(TXB + 1));

        // Full-width payload.
        base = n_done;
        exp_len_q.push_back(16'd8);
        exp_byte_q.push_back(8'h11); exp_byte_q.push_back(8'h22); exp_byte_q.push_back(8'h33);
        exp_byte_q.push_back(8'h44); exp_byte_q.push_back(8'h55); exp_byte_q.push_back(8'h66);
        exp_byte_q.push_back(8'h77); exp_byte_q.push_back(8'h88);
        drive_req(64'h1122_3344_5566_7788, 16'd8);
        wait_done("tx8", base, 8);

        // MAC vanished at CHECK_ARP: re-resolve, then send the retained payload.
        base = n_done; cyc = n_arp;
        exp_len_q.push_back(16'd3);
        exp_byte_q.push_back(8'hA1); exp_byte_q.push_back(8'hB2); exp_byte_q.push_back(8'hC3);
        mac_not_exist = 1'b1;
        drive_req(64'hA1B2_C3FF_FFFF_FFFF, 16'd3);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (arp_req) begin got = 1'b1; break; end
        end
        if (!got) fail("rearp_req_timeout");
        check("rearp_link_down", 64'(link_up), 64'd0);
        @(posedge clk); #1 mac_not_exist = 1'b0;
        wait_done("tx3_rearp", base, 3);
        check("rearp_arp_count", 64'(n_arp - cyc), 64'd1);
        check("rearp_link_up", 64'(link_up), 64'd1);

        // RX packets: short, overflowing, then short again (must clear stale bytes).
        exp_rx_q.push_back('{16'd4, 1'b0, 64'hAABB_CCDD_0000_0000});
        exp_rx_q.push_back('{16'd10, 1'b1, 64'h1011_1213_1415_1617});
        exp_rx_q.push_back('{16'd2, 1'b0, 64'h5A5B_0000_0000_0000});
        rx_burst(8'hAA, 8'h11, 4);
        rx_burst(8'h10, 8'h01, RXB + 2);
        rx_burst(8'h5A, 8'h01, 2);
        repeat (3) @(negedge clk);
        check("rx_packets_left", 64'(exp_rx_q.size()), 64'd0);

        // Idle refresh: leaves READY briefly without requesting a send.
        base = n_req; got = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (!tx_ready) begin got = 1'b1; break; end
        end
        if (!got) fail("refresh_timeout");
        for (int i = 0; i < 5 && !tx_ready; i++) @(negedge clk);
        check("refresh_back_ready", 64'(tx_ready), 64'd1);
        check("refresh_no_request", 64'(n_req - base), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
